// File: rtl/fp_pkg.sv
// Shared binary32 constants and enums for the FP adder normalise/round/pack stage.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = FRAC_W + 1;
  localparam int WORD_W = 1 + EXP_W + FRAC_W;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [2:0] {
    NONE   = 3'b000,
    ZERO   = 3'b001,
    DENORM = 3'b010,
    NAN    = 3'b011,
    INF    = 3'b100
  } exc_e;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } state_e;

endpackage

// File: rtl/fp_rne_round.sv
// fp_rne_round: combinational rounding of a normalised significand with G/R/S.
// FP_NORM_ROUND_RNE_EN selects round-to-nearest-even; otherwise the value is truncated.
module fp_rne_round
  import fp_pkg::*;
(
  input  logic [MANT_W-1:0] mant_i,
  input  logic [2:0]        grs_i,
  input  logic [EXP_W:0]    exp_i,
  output logic [MANT_W-1:0] mant_o,
  output logic [EXP_W:0]    exp_o
);

  logic          inc;
  logic [MANT_W:0] sum;

`ifdef FP_NORM_ROUND_RNE_EN
  assign inc = grs_i[2] & (grs_i[1] | grs_i[0] | mant_i[0]);
`else
  logic unused_grs;
  assign unused_grs = ^grs_i;
  assign inc = 1'b0;
`endif

  assign sum = {1'b0, mant_i} + {{MANT_W{1'b0}}, inc};

  // A carry out of the increment can only come from an all-ones significand, so it renormalises to 1.0
  always_comb begin
    mant_o = sum[MANT_W-1:0];
    exp_o  = exp_i;
    if (sum[MANT_W]) begin
      mant_o = sum[MANT_W:1];
      exp_o  = exp_i + 1'b1;
    end
  end

endmodule

// File: rtl/fp_norm_round.sv
// fp_norm_round: normalises the raw adder sum, rounds it and packs a binary32 word with REQ/ACK.
// Rounding mode is set by the FP_NORM_ROUND_RNE_EN macro (defined: RNE, undefined: truncate).
module fp_norm_round
  import fp_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ,
  input  logic              SIGN,
  input  logic [EXP_W-1:0]  EXP,
  input  logic [MANT_W-1:0] MANT,
  input  logic              COUT,
  input  logic [2:0]        GRS,
  output logic [WORD_W-1:0] DATAOUT,
  output logic [2:0]        EXC,
  output logic              ACK
);

  state_e            state_q;
  logic              sign_q;
  logic [EXP_W:0]    exp_q;
  logic [MANT_W-1:0] mant_q;
  logic              carry_q;
  logic [2:0]        grs_q;
  logic [WORD_W-1:0] data_q, data_d;
  exc_e              exc_q, exc_d;
  logic              ack_q;

  logic [MANT_W-1:0] rndMant;
  logic [EXP_W:0]    rndExp;

  fp_rne_round u_round (
    .mant_i (mant_q),
    .grs_i  (grs_q),
    .exp_i  (exp_q),
    .mant_o (rndMant),
    .exp_o  (rndExp)
  );

  // Zero is judged on the rounded significand together with the pre-rounding G/R/S
  always_comb begin
    data_d = {sign_q, rndExp[EXP_W-1:0], rndMant[FRAC_W-1:0]};
    exc_d  = NONE;
    if (rndMant == '0 && grs_q == 3'b000) begin
      data_d = '0;
      exc_d  = ZERO;
    end else if (rndExp >= {1'b0, EXP_MAX}) begin
      data_d = {sign_q, EXP_MAX, {FRAC_W{1'b0}}};
      exc_d  = INF;
    end else if (rndExp == 9'd1 && !rndMant[MANT_W-1]) begin
      data_d = {sign_q, {EXP_W{1'b0}}, rndMant[FRAC_W-1:0]};
      exc_d  = DENORM;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      mant_q  <= '0;
      carry_q <= 1'b0;
      grs_q   <= 3'b000;
      data_q  <= '0;
      exc_q   <= NONE;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (REQ) begin
            sign_q  <= SIGN;
            exp_q   <= {1'b0, EXP};
            mant_q  <= MANT;
            carry_q <= COUT;
            grs_q   <= GRS;
            state_q <= NORM;
          end
        end
        // Carry shifts right once; otherwise shift left until the integer bit is set or exp hits 1
        NORM: begin
          if (carry_q) begin
            mant_q  <= {carry_q, mant_q[MANT_W-1:1]};
            grs_q   <= {mant_q[0], grs_q[2], grs_q[1] | grs_q[0]};
            exp_q   <= exp_q + 9'd1;
            carry_q <= 1'b0;
            state_q <= ROUND;
          end else if (mant_q[MANT_W-1] || (mant_q == '0 && grs_q == 3'b000) || exp_q == 9'd1) begin
            state_q <= ROUND;
          end else begin
            mant_q <= {mant_q[MANT_W-2:0], grs_q[2]};
            grs_q  <= {grs_q[1], 1'b0, grs_q[0]};
            exp_q  <= exp_q - 9'd1;
          end
        end
        ROUND: begin
          data_q  <= data_d;
          exc_q   <= exc_d;
          state_q <= DONE;
        end
        DONE: begin
          if (!REQ) begin
            ack_q   <= 1'b0;
            state_q <= IDLE;
          end else begin
            ack_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign DATAOUT = data_q;
  assign EXC     = exc_q;
  assign ACK     = ack_q;

endmodule
